// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/halt controller.
// A four-state FSM (RUN, WAIT_MD, HALT, ERR) produces the pipeline enables.
// The enables are combinational in RUN and are forced low in every other state.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   ic_ready          icache has a valid instruction this cycle
//   dc_busy           dcache access outstanding (stalls the whole pipe)
//   ld_use_hazard     ID needs a load result still in EX
//   id_invalid        ID instruction is wrong-path (mispredicted)
//   md_start/md_done  multi-cycle mul/div handshake
//   halt_req          ebreak in EX
//   front_en/back_en  advance PC/IF/ID and EX/MEM/WB
//   ex_bubble         load a NOP into EX
//   id_flush          squash the ID instruction
//   halted            core halted (sticky until rst)
//   md_timeout        mul/div watchdog fired (sticky until rst)
//   stall_cnt         RUN/WAIT_MD cycles with front_en=0, wraps at 2^32
//   flush_cnt         saturating count of id_flush cycles
module pipe_ctrl #(
  parameter int MD_TIMEOUT  = 63,
  parameter int FLUSH_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ic_ready,
  input  logic                   dc_busy,
  input  logic                   ld_use_hazard,
  input  logic                   id_invalid,
  input  logic                   md_start,
  input  logic                   md_done,
  input  logic                   halt_req,
  output logic                   front_en,
  output logic                   back_en,
  output logic                   ex_bubble,
  output logic                   id_flush,
  output logic                   halted,
  output logic                   md_timeout,
  output logic [31:0]            stall_cnt,
  output logic [FLUSH_CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_WAIT_MD = 2'd1;
  localparam logic [1:0] S_HALT    = 2'd2;
  localparam logic [1:0] S_ERR     = 2'd3;

  // The watchdog only has to reach MD_TIMEOUT (6 bits for the default of 63).
  localparam int WD_W = (MD_TIMEOUT < 2) ? 1 : $clog2(MD_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MD_TIMEOUT);

  logic [1:0]             r_state;
  logic [WD_W-1:0]        r_wd;
  logic [31:0]            r_stall_cnt;
  logic [FLUSH_CNT_W-1:0] r_flush_cnt;

  logic       w_front_en;
  logic       w_back_en;
  logic       w_ex_bubble;
  logic       w_id_flush;
  logic [1:0] w_next;

  // Enables. All of them are low while rst is high and outside RUN.
  // id_invalid masks the load-use hazard: a wrong-path consumer is squashed,
  // so it does not need to wait for the load.
  always_comb begin
    w_front_en  = 1'b0;
    w_back_en   = 1'b0;
    w_ex_bubble = 1'b0;
    if (!rst && r_state == S_RUN) begin
      if (dc_busy) begin
        w_back_en = 1'b0;
      end else if (!ic_ready || (ld_use_hazard && !id_invalid)) begin
        w_back_en   = 1'b1;
        w_ex_bubble = 1'b1;
      end else begin
        w_front_en = 1'b1;
        w_back_en  = 1'b1;
      end
    end
  end

  assign w_id_flush = id_invalid && w_back_en;

  // Next state. halt_req and md_start are only sampled while the back end moves.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RUN: begin
        if (w_back_en) begin
          if (halt_req)      w_next = S_HALT;
          else if (md_start) w_next = S_WAIT_MD;
        end
      end
      S_WAIT_MD: begin
        // md_done takes priority over a timeout in the same cycle.
        if (md_done)               w_next = S_RUN;
        else if (r_wd == WD_MAX)   w_next = S_ERR;
      end
      default: w_next = r_state;  // HALT and ERR are left only by rst
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_wd        <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next;

      if (r_state == S_RUN && w_next == S_WAIT_MD)
        r_wd <= '0;
      else if (r_state == S_WAIT_MD)
        r_wd <= r_wd + 1'b1;

      if ((r_state == S_RUN || r_state == S_WAIT_MD) && !w_front_en)
        r_stall_cnt <= r_stall_cnt + 32'd1;

      if (w_id_flush && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // Every output reads 0 while rst is high, whatever the held state is.
  assign front_en   = w_front_en;
  assign back_en    = w_back_en;
  assign ex_bubble  = w_ex_bubble;
  assign id_flush   = w_id_flush;
  assign halted     = !rst && r_state == S_HALT;
  assign md_timeout = !rst && r_state == S_ERR;
  assign stall_cnt  = rst ? 32'd0 : r_stall_cnt;
  assign flush_cnt  = rst ? '0 : r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst, ic_ready, dc_busy, ld_use_hazard, id_invalid, md_start, md_done, halt_req;
  logic front_en, back_en, ex_bubble, id_flush, halted, md_timeout;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic f2, b2, x2, i2, h2, t2;
  logic [31:0] s2;
  logic [1:0]  flush_cnt2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .ic_ready(ic_ready), .dc_busy(dc_busy),
    .ld_use_hazard(ld_use_hazard), .id_invalid(id_invalid), .md_start(md_start),
    .md_done(md_done), .halt_req(halt_req), .front_en(front_en), .back_en(back_en),
    .ex_bubble(ex_bubble), .id_flush(id_flush), .halted(halted),
    .md_timeout(md_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow flush counter instance: 2'b10 / 2'b11 stand in for 16'hFFFE / 16'hFFFF.
  pipe_ctrl #(.MD_TIMEOUT(63), .FLUSH_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .ic_ready(ic_ready), .dc_busy(dc_busy),
    .ld_use_hazard(ld_use_hazard), .id_invalid(id_invalid), .md_start(md_start),
    .md_done(md_done), .halt_req(halt_req), .front_en(f2), .back_en(b2),
    .ex_bubble(x2), .id_flush(i2), .halted(h2),
    .md_timeout(t2), .stall_cnt(s2), .flush_cnt(flush_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {front_en, back_en, ex_bubble, id_flush}
  task automatic chk_en(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, front_en, back_en, ex_bubble, id_flush}, {28'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ic_ready = 1'b1; dc_busy = 1'b0; ld_use_hazard = 1'b0; id_invalid = 1'b0;
    md_start = 1'b0; md_done = 1'b0; halt_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset with hostile inputs: every output must read 0.
    rst = 1'b1; idle(); id_invalid = 1'b1; halt_req = 1'b1; md_start = 1'b1;
    #1;
    chk_en("rst_en_forced", 4'b0000);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_md_timeout", {31'd0, md_timeout}, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_flush", {16'd0, flush_cnt}, 32'd0);
    tick(); tick();
    chk_en("rst_en_held", 4'b0000);
    idle(); rst = 1'b0; #1;
    chk_en("first_after_rst", 4'b1100);
    chk("not_halted_after_rst", {31'd0, halted}, 32'd0);

    // Free run for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      chk_en("free_run", 4'b1100);
      tick();
    end
    chk("free_stall", stall_cnt, 32'd0);
    chk("free_flush", {16'd0, flush_cnt}, 32'd0);

    // Load-use hazard.
    ld_use_hazard = 1'b1; #1;
    chk_en("ld_use", 4'b0110);
    tick(); idle(); #1;
    chk("ld_use_stall", stall_cnt, 32'd1);

    // Hazard masked by wrong-path ID.
    ld_use_hazard = 1'b1; id_invalid = 1'b1; #1;
    chk_en("ld_use_invalid", 4'b1101);
    tick(); idle(); #1;
    chk("flush_one", {16'd0, flush_cnt}, 32'd1);
    chk("stall_unchanged", stall_cnt, 32'd1);

    // icache miss, and a flush during the miss bubble.
    ic_ready = 1'b0; #1;
    chk_en("ic_miss", 4'b0110);
    id_invalid = 1'b1; #1;
    chk_en("ic_miss_flush", 4'b0111);
    tick(); idle(); #1;
    chk("ic_miss_stall", stall_cnt, 32'd2);
    chk("ic_miss_flush_cnt", {16'd0, flush_cnt}, 32'd2);

    // dcache busy dominates everything.
    dc_busy = 1'b1; ic_ready = 1'b0; ld_use_hazard = 1'b1; id_invalid = 1'b1; #1;
    chk_en("dc_busy", 4'b0000);
    tick(); idle(); #1;
    chk("dc_busy_stall", stall_cnt, 32'd3);
    chk("dc_busy_no_flush", {16'd0, flush_cnt}, 32'd2);

    // mul/div: 5 WAIT_MD cycles, md_done on the 5th.
    md_start = 1'b1; #1;
    chk_en("md_start_run", 4'b1100);
    tick(); idle();
    for (int k = 1; k <= 5; k++) begin
      md_done = (k == 5);
      id_invalid = 1'b1;
      #1;
      chk_en("wait_md", 4'b0000);
      tick();
    end
    idle(); #1;
    chk_en("md_resume", 4'b1100);
    chk("md_stall", stall_cnt, 32'd8);
    chk("md_no_flush", {16'd0, flush_cnt}, 32'd2);

    // halt_req + md_start while dc_busy: ignored.
    halt_req = 1'b1; md_start = 1'b1; dc_busy = 1'b1; #1;
    tick(); idle(); #1;
    chk("halt_ignored", {31'd0, halted}, 32'd0);
    chk_en("halt_ignored_run", 4'b1100);
    chk("halt_ignored_stall", stall_cnt, 32'd9);

    // halt_req wins over md_start.
    halt_req = 1'b1; md_start = 1'b1; #1;
    tick(); idle(); id_invalid = 1'b1; md_done = 1'b1; #1;
    for (int i = 0; i < 20; i++) begin
      chk("halted_held", {31'd0, halted}, 32'd1);
      chk_en("halt_en", 4'b0000);
      tick();
    end
    chk("halt_no_stall", stall_cnt, 32'd9);
    chk("halt_no_flush", {16'd0, flush_cnt}, 32'd2);
    chk("halt_no_timeout", {31'd0, md_timeout}, 32'd0);
    idle();
    rst = 1'b1; #1;
    chk("halted_forced_in_rst", {31'd0, halted}, 32'd0);
    tick(); rst = 1'b0; #1;
    chk("halt_cleared", {31'd0, halted}, 32'd0);
    chk_en("halt_cleared_run", 4'b1100);
    chk("halt_rst_stall", stall_cnt, 32'd0);

    // Watchdog timeout: 64 WAIT_MD cycles then ERR.
    md_start = 1'b1; tick(); idle();
    for (int i = 0; i < 64; i++) begin
      if (i == 0 || i == 63) begin
        #1;
        chk("wd_not_yet", {31'd0, md_timeout}, 32'd0);
        chk_en("wd_en", 4'b0000);
      end
      tick();
    end
    chk("wd_timeout", {31'd0, md_timeout}, 32'd1);
    chk_en("err_en", 4'b0000);
    md_done = 1'b1; tick(); tick(); idle(); #1;
    chk("err_sticky", {31'd0, md_timeout}, 32'd1);
    chk("err_no_stall", stall_cnt, 32'd64);
    do_reset();
    chk("err_cleared", {31'd0, md_timeout}, 32'd0);
    chk_en("err_cleared_run", 4'b1100);

    // md_done on the final watchdog cycle wins.
    md_start = 1'b1; tick(); idle();
    for (int i = 0; i < 63; i++) tick();
    md_done = 1'b1; #1;
    chk("wd_edge_not_err", {31'd0, md_timeout}, 32'd0);
    tick(); idle(); #1;
    chk("wd_edge_resume", {31'd0, md_timeout}, 32'd0);
    chk_en("wd_edge_run", 4'b1100);
    chk("wd_edge_stall", stall_cnt, 32'd64);

    // Flush counter saturation (narrow instance).
    do_reset();
    id_invalid = 1'b1;
    tick(); tick();
    chk("sat_pre", {30'd0, flush_cnt2}, 32'd2);
    tick(); tick(); tick();
    chk("sat_held", {30'd0, flush_cnt2}, 32'd3);
    chk("wide_flush", {16'd0, flush_cnt}, 32'd5);
    idle(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MD_TIMEOUT, default 63: maximum number of WAIT_MD cycles before timeout.
REQ-002 Parameter FLUSH_CNT_W, default 16: width of flush_cnt.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ic_ready  input  1  icache presents a valid instruction this cycle.
REQ-006 dc_busy  input  1  dcache access outstanding; stalls the whole pipe.
REQ-007 ld_use_hazard  input  1  ID instruction needs a load result that is still in EX.
REQ-008 id_invalid  input  1  predictor misprediction; the ID instruction is wrong-path.
REQ-009 md_start  input  1  EX holds a multi-cycle mul/div.
REQ-010 md_done  input  1  mul/div result valid.
REQ-011 halt_req  input  1  EX holds ebreak.
REQ-012 front_en  output  1  advance PC/IF/ID; drives the predictor pipeline_en.
REQ-013 back_en  output  1  advance EX/MEM/WB.
REQ-014 ex_bubble  output  1  load a NOP into EX instead of the ID instruction.
REQ-015 id_flush  output  1  squash the ID instruction.
REQ-016 halted  output  1  core halted.
REQ-017 md_timeout  output  1  sticky mul/div watchdog error.
REQ-018 stall_cnt  output  32  cycles with front_en=0, excluding HALT and ERR.
REQ-019 flush_cnt  output  FLUSH_CNT_W  saturating count of id_flush cycles.

Function
REQ-020 The FSM shall have states RUN, WAIT_MD, HALT and ERR.
REQ-021 In RUN, enables shall be combinational, evaluated in this priority order:
- dc_busy=1: front_en=0, back_en=0, ex_bubble=0.
- else ic_ready=0: front_en=0, back_en=1, ex_bubble=1.
- else (ld_use_hazard & !id_invalid)=1: front_en=0, back_en=1, ex_bubble=1.
- else: front_en=1, back_en=1, ex_bubble=0.
REQ-022 id_flush shall equal id_invalid & back_en & (state==RUN); id_invalid shall mask ld_use_hazard.
REQ-023 halt_req and md_start shall be sampled only in RUN with back_en=1; otherwise they are ignored.
REQ-024 In RUN with back_en=1:
- halt_req=1: next state HALT; halt_req wins over a simultaneous md_start.
- else md_start=1: next state WAIT_MD and the watchdog clears to 0.
REQ-025 WAIT_MD: front_en=back_en=ex_bubble=id_flush=0; the 6-bit watchdog shall increment each cycle.
REQ-026 In WAIT_MD, md_done=1 shall return the FSM to RUN next cycle.
REQ-027 In WAIT_MD, when the watchdog equals MD_TIMEOUT and md_done=0, the next state shall be ERR; md_done in that same cycle wins and returns to RUN.
REQ-028 HALT: all enables 0, halted=1; HALT is left only by rst.
REQ-029 ERR: all enables 0, md_timeout=1; ERR is left only by rst.
REQ-030 stall_cnt shall increment by 1 in every RUN or WAIT_MD cycle with front_en=0, wrapping modulo 2^32.
REQ-031 flush_cnt shall increment on every cycle with id_flush=1 and saturate at all-ones.
REQ-032 Outputs in the cycle rst is high shall be forced to 0 regardless of inputs.

Reset
REQ-033 On rst=1, the following shall take effect at the next edge, including mid-WAIT_MD, HALT or ERR: state=RUN, watchdog=0, stall_cnt=0, flush_cnt=0, halted=0, md_timeout=0.
REQ-034 In the first cycle after rst deasserts, outputs shall follow REQ-021 from the current inputs.

Verification
REQ-035 Release rst, ic_ready=1, other inputs 0 for 10 cycles -> front_en=back_en=1 every cycle; stall_cnt=0, flush_cnt=0.
REQ-036 ld_use_hazard=1 for 1 cycle -> front_en=0, back_en=1, ex_bubble=1, stall_cnt=1; the same stimulus with id_invalid=1 -> front_en=1, id_flush=1, flush_cnt=1.
REQ-037 md_start=1 for 1 cycle, then md_done=1 after 5 cycles -> 5 WAIT_MD cycles with all enables 0, RUN resumes next cycle, stall_cnt=5.
REQ-038 md_start=1, md_done never asserted -> md_timeout=1 after 64 WAIT_MD cycles, enables stay 0; rst pulse -> md_timeout=0, state RUN.
REQ-039 halt_req=1 and md_start=1 together with dc_busy=0 -> HALT, halted=1 held for 20 cycles; the same pair with dc_busy=1 -> ignored, state stays RUN.
REQ-040 Force flush_cnt=FFFE, then id_flush for 3 cycles -> flush_cnt=FFFF and held.
